// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM block-transfer sequencer: walks a register list lowest-first,
// issuing one req/ack memory beat per register and driving the register bank.
module ldm_stm_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RF_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    input  logic [DATA_W-1:0] rf_read1,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [RF_AW-1:0]  rf_address1,
    output logic [DATA_W-1:0] rf_write,
    output logic              rf_w,
    output logic [DATA_W-1:0] pc_write,
    output logic              pc_w,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RD, S_MEM, S_WR, S_BASE_WB, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              is_load_q, up_q, pre_q, wb_q, wb_en_q;
    logic [3:0]        base_reg_q;
    logic [DATA_W-1:0] base_q, addr_q, data_q, final_q;
    logic [15:0]       list_q;

    logic [3:0]        cur;
    logic [15:0]       rem;
    logic [4:0]        n_regs;
    logic [DATA_W-1:0] span, start_addr, final_val;
    logic              wb_en_c;

    // Current register is the lowest set bit of the remaining list.
    always_comb begin
        cur    = 4'd0;
        n_regs = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) cur = 4'(i);
            n_regs = n_regs + 5'(list_q[i]);
        end
        rem = list_q & ~(16'd1 << cur);
    end

    // Descending modes still issue ascending addresses starting below the base.
    always_comb begin
        span       = DATA_W'(n_regs) << 2;
        final_val  = up_q ? base_q + span : base_q - span;
        if (up_q) start_addr = pre_q ? base_q + DATA_W'(4) : base_q;
        else      start_addr = pre_q ? base_q - span : base_q - span + DATA_W'(4);
        wb_en_c    = wb_q && (base_reg_q != 4'd15) && !(is_load_q && list_q[base_reg_q]);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SETUP;
            S_SETUP:   if (list_q == 16'd0) state_nxt = S_DONE;
                       else                 state_nxt = is_load_q ? S_MEM : S_RD;
            S_RD:      state_nxt = S_MEM;
            S_MEM:     if (mem_ack) begin
                           if (is_load_q)          state_nxt = S_WR;
                           else if (rem != 16'd0)  state_nxt = S_RD;
                           else                    state_nxt = wb_en_q ? S_BASE_WB : S_DONE;
                       end
            S_WR:      if (rem != 16'd0) state_nxt = S_MEM;
                       else              state_nxt = wb_en_q ? S_BASE_WB : S_DONE;
            S_BASE_WB: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Transfer datapath: latched command, beat address and beat data.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_load_q  <= 1'b0;
            up_q       <= 1'b0;
            pre_q      <= 1'b0;
            wb_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            base_reg_q <= 4'd0;
            base_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            final_q    <= '0;
            list_q     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    is_load_q  <= is_load;
                    up_q       <= up;
                    pre_q      <= pre;
                    wb_q       <= writeback;
                    base_reg_q <= base_reg;
                    base_q     <= base_addr;
                    list_q     <= reg_list;
                end
                S_SETUP: begin
                    addr_q  <= start_addr;
                    final_q <= final_val;
                    wb_en_q <= wb_en_c;
                end
                S_RD: data_q <= rf_read1;
                S_MEM: if (mem_ack) begin
                    addr_q <= addr_q + DATA_W'(4);
                    if (is_load_q) data_q <= mem_rdata;
                    else           list_q <= rem;
                end
                S_WR: list_q <= rem;
                default: ;
            endcase
        end
    end

    // Outputs decode purely from registered state, so reset clears them at once.
    always_comb begin
        rf_address1 = '0;
        rf_write    = '0;
        rf_w        = 1'b0;
        pc_write    = '0;
        pc_w        = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        case (state)
            S_RD: rf_address1 = RF_AW'(cur);
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = ~is_load_q;
                mem_addr  = addr_q & ~DATA_W'(3);
                mem_wdata = is_load_q ? '0 : data_q;
            end
            S_WR: begin
                if (cur == 4'd15) begin
                    pc_w     = 1'b1;
                    pc_write = data_q & ~DATA_W'(3);
                end else begin
                    rf_w        = 1'b1;
                    rf_address1 = RF_AW'(cur);
                    rf_write    = data_q;
                end
            end
            S_BASE_WB: begin
                rf_w        = 1'b1;
                rf_address1 = RF_AW'(base_reg_q);
                rf_write    = final_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a simple bank and memory responder.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, is_load, up, pre, writeback;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic [31:0] rf_read1, mem_rdata;
    logic        mem_ack;
    logic [4:0]  rf_address1;
    logic [31:0] rf_write, pc_write, mem_addr, mem_wdata;
    logic        rf_w, pc_w, mem_req, mem_we, busy, done;
    logic        ack_en;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    // Bank returns 0xA000_0000 | index; memory returns 0xC0DE_0003 ^ address.
    assign rf_read1  = 32'hA000_0000 | 32'(rf_address1);
    assign mem_rdata = 32'hC0DE_0003 ^ {16'h0, mem_addr[15:0]};
    assign mem_ack   = mem_req & ack_en;

    ldm_stm_sequencer #(.DATA_W(32), .RF_AW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
        .pre(pre), .writeback(writeback), .base_reg(base_reg),
        .base_addr(base_addr), .reg_list(reg_list), .rf_read1(rf_read1),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_address1(rf_address1),
        .rf_write(rf_write), .rf_w(rf_w), .pc_write(pc_write), .pc_w(pc_w),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic u, input logic p, input logic wb,
                         input logic [3:0] br, input logic [31:0] ba, input logic [15:0] rl);
        is_load = ld; up = u; pre = p; writeback = wb;
        base_reg = br; base_addr = ba; reg_list = rl;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0;
        writeback = 1'b0; base_reg = 4'd0; base_addr = 32'd0; reg_list = 16'd0;
        ack_en = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // STMIA r13!, {r1,r3}
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h000A);
        chk("t1_setup_busy", 32'(busy), 1);
        chk("t1_setup_req", 32'(mem_req), 0);
        tick(); chk("t1_rd1_addr", 32'(rf_address1), 1);
        tick(); chk("t1_m1_addr", mem_addr, 32'h100);
        chk("t1_m1_data", mem_wdata, 32'hA000_0001);
        chk("t1_m1_we", 32'(mem_we), 1);
        tick(); chk("t1_rd3_addr", 32'(rf_address1), 3);
        chk("t1_rd3_req", 32'(mem_req), 0);
        tick(); chk("t1_m2_addr", mem_addr, 32'h104);
        chk("t1_m2_data", mem_wdata, 32'hA000_0003);
        tick(); chk("t1_wb_w", 32'(rf_w), 1);
        chk("t1_wb_reg", 32'(rf_address1), 13);
        chk("t1_wb_val", rf_write, 32'h108);
        tick(); chk("t1_done", 32'(done), 1);
        tick(); chk("t1_done_once", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);

        // LDMDB r4!, {r0,r1,pc}
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h200, 16'h8003);
        tick(); chk("t2_m0_addr", mem_addr, 32'h1F4);
        chk("t2_m0_we", 32'(mem_we), 0);
        tick(); chk("t2_wr0_w", 32'(rf_w), 1);
        chk("t2_wr0_reg", 32'(rf_address1), 0);
        chk("t2_wr0_val", rf_write, 32'hC0DE_01F7);
        tick(); chk("t2_m1_addr", mem_addr, 32'h1F8);
        tick(); chk("t2_wr1_val", rf_write, 32'hC0DE_01FB);
        chk("t2_wr1_reg", 32'(rf_address1), 1);
        tick(); chk("t2_m2_addr", mem_addr, 32'h1FC);
        tick(); chk("t2_pc_w", 32'(pc_w), 1);
        chk("t2_pc_rfw", 32'(rf_w), 0);
        chk("t2_pc_val", pc_write, 32'hC0DE_01FC);
        tick(); chk("t2_wb_reg", 32'(rf_address1), 4);
        chk("t2_wb_val", rf_write, 32'h1F4);
        chk("t2_wb_w", 32'(rf_w), 1);
        tick(); chk("t2_done", 32'(done), 1);
        tick();

        // STMIB {r4,r5} with a 5-cycle ack stall on the second beat
        issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h40, 16'h0030);
        tick(); chk("t3_rd4", 32'(rf_address1), 4);
        tick(); chk("t3_m1_addr", mem_addr, 32'h44);
        chk("t3_m1_data", mem_wdata, 32'hA000_0004);
        tick(); chk("t3_rd5", 32'(rf_address1), 5);
        ack_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_addr", mem_addr, 32'h48);
            chk("t3_hold_data", mem_wdata, 32'hA000_0005);
            chk("t3_hold_req", 32'(mem_req), 1);
        end
        ack_en = 1'b1;
        tick(); chk("t3_done", 32'(done), 1);
        chk("t3_no_wb", 32'(rf_w), 0);
        tick();

        // Empty list; start held high through DONE must be ignored
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h80, 16'h0000);
        chk("t4_setup_done", 32'(done), 0);
        chk("t4_setup_req", 32'(mem_req), 0);
        start = 1'b1;
        tick(); chk("t4_done", 32'(done), 1);
        chk("t4_req", 32'(mem_req), 0);
        chk("t4_rfw", 32'(rf_w), 0);
        tick(); chk("t4_idle", 32'(busy), 0);
        start = 1'b0;
        tick(); chk("t4_stay_idle", 32'(busy), 0);

        // LDMIA r2!, {r1,r2}: loaded base wins, no writeback
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0006);
        tick(); chk("t5_m1_addr", mem_addr, 32'h300);
        tick(); chk("t5_wr1_val", rf_write, 32'hC0DE_0303);
        tick(); chk("t5_m2_addr", mem_addr, 32'h304);
        tick(); chk("t5_wr2_reg", 32'(rf_address1), 2);
        chk("t5_wr2_val", rf_write, 32'hC0DE_0307);
        tick(); chk("t5_done", 32'(done), 1);
        chk("t5_no_wb", 32'(rf_w), 0);
        tick();

        // Reset during a stalled beat of a 4-register LDM
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h80, 16'h00F0);
        ack_en = 1'b0;
        tick(); chk("t6_req", 32'(mem_req), 1);
        reset = 1'b1;
        tick();
        chk("t6_rst_req", 32'(mem_req), 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_rfw", 32'(rf_w), 0);
        chk("t6_rst_pcw", 32'(pc_w), 0);
        reset = 1'b0;
        ack_en = 1'b1;
        tick(); chk("t6_idle_req", 32'(mem_req), 0);
        chk("t6_idle_rfw", 32'(rf_w), 0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h10, 16'h0001);
        tick(); chk("t6_rd0", 32'(rf_address1), 0);
        tick(); chk("t6_m_addr", mem_addr, 32'h10);
        chk("t6_m_data", mem_wdata, 32'hA000_0000);
        tick(); chk("t6_done", 32'(done), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
